// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DROP,
      HALT
   } fetch_state_t;

   localparam int INSTR_BYTES = 4;
   localparam int INSTR_W     = 32;

endpackage

// File: rtl/fetch_ctrl_fetchbuf.sv
// One-entry holding buffer for a fetched word that ID could not accept yet.
module fetchbuf
   import fetch_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               nrst,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] din,
   output logic [INSTR_W-1:0] dout,
   output logic               full
);

   logic [INSTR_W-1:0] data_q, data_d;
   logic               full_q, full_d;

   // clear wins over load so a redirect always empties the buffer
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (load) begin
         data_d = din;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, IF/ID register,
// branch/jump redirect with in-flight response dropping, sticky misalign halt.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int          n        = 32,
   parameter logic [n-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               brnch,
   input  logic               isbr,
   input  logic               jmp,
   input  logic [n-1:0]       tgt,
   input  logic               stall,
   output logic               imem_req,
   output logic [n-1:0]       imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [n-1:0]       if_pc,
   output logic               flush,
   output logic               misalign
);

   fetch_state_t       state_q, state_d;
   logic [n-1:0]       pc_q, pc_d;
   logic               if_valid_q, if_valid_d;
   logic [INSTR_W-1:0] if_instr_q, if_instr_d;
   logic [n-1:0]       if_pc_q, if_pc_d;
   logic               misalign_q, misalign_d;

   logic               take_ok, bad_tgt;
   logic               cap;
   logic [INSTR_W-1:0] cap_instr;
   logic               buf_load, buf_clear, buf_full;
   logic [INSTR_W-1:0] buf_dout;

   // A halted fetch unit ignores redirects entirely.
   assign take_ok = ((isbr & brnch) | jmp) & (state_q != HALT);
   assign bad_tgt = (tgt[1:0] != 2'b00);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (take_ok && bad_tgt) begin
         state_d = HALT;
      end else begin
         case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (imem_gnt) state_d = take_ok ? DROP : WAIT;
            WAIT: begin
               if (take_ok)          state_d = imem_rvalid ? REQ : DROP;
               else if (imem_rvalid) state_d = stall ? HOLD : REQ;
            end
            HOLD: if (take_ok || !stall) state_d = REQ;
            DROP: if (imem_rvalid) state_d = REQ;
            HALT: state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      imem_req = (state_q == REQ);
      flush    = take_ok;
   end

   // Datapath: PC, IF/ID register, buffer control and the sticky fault.
   always_comb begin
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      misalign_d = misalign_q;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;
      cap        = 1'b0;
      cap_instr  = '0;
      if (take_ok) begin
         buf_clear  = 1'b1;
         if_valid_d = 1'b0;
         if (bad_tgt) misalign_d = 1'b1;
         else         pc_d       = tgt;
      end else begin
         case (state_q)
            WAIT: begin
               if (imem_rvalid) begin
                  if (stall) begin
                     buf_load = 1'b1;
                  end else begin
                     cap       = 1'b1;
                     cap_instr = imem_rdata;
                  end
               end
            end
            HOLD: begin
               if (!stall && buf_full) begin
                  cap       = 1'b1;
                  cap_instr = buf_dout;
                  buf_clear = 1'b1;
               end
            end
            default: ;
         endcase
         // pc still names the captured word until the capture edge advances it
         if (cap) begin
            if_valid_d = 1'b1;
            if_instr_d = cap_instr;
            if_pc_d    = pc_q;
            pc_d       = pc_q + n'(INSTR_BYTES);
         end else if (!stall) begin
            if_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetchbuf u_fetchbuf (
      .clk   (clk),
      .nrst  (nrst),
      .load  (buf_load),
      .clear (buf_clear),
      .din   (imem_rdata),
      .dout  (buf_dout),
      .full  (buf_full)
   );

   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model of which fetched words must reach IF/ID.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        nrst;
   logic        brnch, isbr, jmp, stall;
   logic [31:0] tgt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr, if_pc;
   logic        flush, misalign;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];

   fetch_ctrl #(.n(32), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .brnch       (brnch),
      .isbr        (isbr),
      .jmp         (jmp),
      .tgt         (tgt),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .flush       (flush),
      .misalign    (misalign)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      brnch = 1'b0; isbr = 1'b0; jmp = 1'b0; stall = 1'b0;
      tgt = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_0013;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      nrst = 1'b0;
      idle_inputs();
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      repeat (2) tick();
      total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
      total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); end
      total++; if (if_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
      total++; if (if_instr !== 32'h0)   begin bad++; $display("FAIL rst_instr: got %h want 0", if_instr); end
      total++; if (if_pc !== 32'h0)      begin bad++; $display("FAIL rst_pc: got %h want 0", if_pc); end
      total++; if (misalign !== 1'b0)    begin bad++; $display("FAIL rst_misalign: got %b want 0", misalign); end
      idle_inputs();
      nrst = 1'b1;
   endtask

   task automatic test_sequential();
      int cnt = 0;
      do_reset();
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_idle_req: got %b want 0", imem_req); end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (c == 0) begin
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_req_rise: got %b want 1", imem_req); end
         end
         if (if_valid === 1'b1 && cnt < 3) begin
            total++;
            if (if_pc !== RST_PC + 32'(4 * cnt)) begin
               bad++; $display("FAIL seq_pc%0d: got %h want %h", cnt, if_pc, RST_PC + 32'(4 * cnt));
            end
            total++; if (if_instr !== 32'h0000_0013) begin bad++; $display("FAIL seq_instr: got %h want 00000013", if_instr); end
            cnt++;
         end
      end
      total++; if (cnt != 3) begin bad++; $display("FAIL seq_count: got %0d want 3", cnt); end
      idle_inputs();
   endtask

   task automatic test_branch_wait();
      do_reset();
      tick();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL br_one_outstanding: got %b want 0", imem_req); end
      isbr = 1'b1; brnch = 1'b1; tgt = 32'h200;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush: got %b want 1", flush); end
      tick();
      isbr = 1'b0; brnch = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL br_drop: got %b want 0", if_valid); end
      #1;
      total++; if (imem_req !== 1'b1)     begin bad++; $display("FAIL br_req: got %b want 1", imem_req); end
      total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL br_addr: got %h want 00000200", imem_addr); end
      idle_inputs();
   endtask

   task automatic test_stall_hold();
      do_reset();
      tick();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
      tick();
      imem_rvalid = 1'b0; imem_rdata = '0;
      for (int k = 0; k < 2; k++) begin
         #1;
         total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req%0d: got %b want 0", k, imem_req); end
         tick();
      end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL hold_valid: got %b want 0", if_valid); end
      stall = 1'b0;
      tick();
      total++; if (if_valid !== 1'b1)          begin bad++; $display("FAIL hold_rel_valid: got %b want 1", if_valid); end
      total++; if (if_instr !== 32'h0050_0093) begin bad++; $display("FAIL hold_rel_instr: got %h want 00500093", if_instr); end
      total++; if (if_pc !== RST_PC)           begin bad++; $display("FAIL hold_rel_pc: got %h want %h", if_pc, RST_PC); end
      #1;
      total++; if (imem_addr !== RST_PC + 32'd4) begin bad++; $display("FAIL hold_next_addr: got %h want %h", imem_addr, RST_PC + 32'd4); end
      idle_inputs();
   endtask

   task automatic test_misalign();
      do_reset();
      tick();
      jmp = 1'b1; tgt = 32'h202;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL mis_flush: got %b want 1", flush); end
      tick();
      jmp = 1'b0;
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_set: got %b want 1", misalign); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL mis_valid: got %b want 0", if_valid); end
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; tgt = 32'h300;
      for (int k = 0; k < 10; k++) begin
         jmp = k[0];
         #1;
         total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mis_req%0d: got %b want 0", k, imem_req); end
         total++; if (flush !== 1'b0)    begin bad++; $display("FAIL mis_noflush%0d: got %b want 0", k, flush); end
         tick();
         total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL mis_novalid%0d: got %b want 0", k, if_valid); end
      end
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky: got %b want 1", misalign); end
      nrst = 1'b0;
      idle_inputs();
      #1;
      total++; if (misalign !== 1'b0)    begin bad++; $display("FAIL mis_clear: got %b want 0", misalign); end
      total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL mis_pc: got %h want %h", imem_addr, RST_PC); end
      tick();
      nrst = 1'b1;
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      jmp = 1'b1; tgt = 32'hFFFF_FFFC;
      tick();
      jmp = 1'b0;
      #1;
      total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
      tick();
      imem_rvalid = 1'b0;
      total++; if (if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_ifpc: got %h want fffffffc", if_pc); end
      #1;
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
      idle_inputs();
   endtask

   task automatic test_take_stall();
      do_reset();
      tick();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
      tick();
      imem_rvalid = 1'b0;
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL ts_pre_valid: got %b want 1", if_valid); end
      stall = 1'b1; jmp = 1'b1; tgt = 32'h300;
      tick();
      jmp = 1'b0;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL ts_valid: got %b want 0", if_valid); end
      #1;
      total++; if (imem_addr !== 32'h300) begin bad++; $display("FAIL ts_pc: got %h want 00000300", imem_addr); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      nrst = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", imem_req); end
      tick();
      nrst = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rm_valid%0d: got %b want 0", k, if_valid); end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [31:0] next_addr, out_addr, r, m_instr, m_pc;
      logic        outstanding, tainted, grant, take, m_valid;
      logic [63:0] e;
      for (int i = 0; i < 3000; i++) begin
         if (i == 0 || i == 1500) begin
            do_reset();
            next_addr = RST_PC; out_addr = '0; outstanding = 1'b0; tainted = 1'b0;
            m_valid = 1'b0; m_instr = '0; m_pc = '0;
            exp_q.delete();
         end
         isbr  = ($urandom_range(0, 3) == 0);
         brnch = 1'($urandom_range(0, 1));
         jmp   = ($urandom_range(0, 15) == 0);
         r     = $urandom;
         tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
         stall = ($urandom_range(0, 3) == 0);
         imem_gnt    = 1'($urandom_range(0, 1));
         imem_rvalid = outstanding && ($urandom_range(0, 2) != 0);
         imem_rdata  = imem_rvalid ? mem_word(out_addr) : $urandom;
         #1;
         take = (isbr & brnch) | jmp;
         total++; if (flush !== take) begin bad++; $display("FAIL rnd_flush@%0d: got %b want %b", i, flush, take); end
         if (imem_req === 1'b1) begin
            total++; if (imem_addr !== next_addr) begin bad++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, next_addr); end
         end
         if (outstanding || exp_q.size() != 0) begin
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rnd_busy_req@%0d: got %b want 0", i, imem_req); end
         end
         grant = (imem_req === 1'b1) && imem_gnt && !outstanding;
         tick();
         // a response survives only if no redirect happened from grant to arrival
         if (grant) begin
            out_addr = next_addr; outstanding = 1'b1; tainted = take;
         end else if (outstanding) begin
            tainted = tainted | take;
            if (imem_rvalid) begin
               outstanding = 1'b0;
               if (!tainted) exp_q.push_back({out_addr, mem_word(out_addr)});
            end
         end
         if (take) begin
            m_valid = 1'b0; exp_q.delete(); next_addr = tgt;
         end else if (!stall) begin
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               m_valid = 1'b1; m_pc = e[63:32]; m_instr = e[31:0];
               next_addr = m_pc + 32'd4;
            end else begin
               m_valid = 1'b0;
            end
         end
         total++; if (if_valid !== m_valid) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, if_valid, m_valid); end
         if (m_valid) begin
            total++; if (if_pc !== m_pc)       begin bad++; $display("FAIL rnd_pc@%0d: got %h want %h", i, if_pc, m_pc); end
            total++; if (if_instr !== m_instr) begin bad++; $display("FAIL rnd_instr@%0d: got %h want %h", i, if_instr, m_instr); end
         end
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      nrst = 1'b0;
      idle_inputs();
      test_reset();
      test_sequential();
      test_branch_wait();
      test_stall_hold();
      test_misalign();
      test_wrap();
      test_take_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
